// File: rtl/pe_pkg.sv
// Shared constants and types for the inner-product PE datapath.
// Lane geometry is common to the multiplier array and the reduction back end.
package pe_pkg;

    localparam int LANES  = 32;
    localparam int PROD_W = 32;
    localparam int ACC_W  = 48;
    localparam int OUT_W  = 32;
    localparam int CNT_W  = 16;

    // Width of one lane slice on the product bus, shared with the multiplier array.
    localparam int LANE_W = PROD_W;

    localparam logic signed [31:0] INT32_MAX = 32'sh7FFF_FFFF;
    localparam logic signed [31:0] INT32_MIN = 32'sh8000_0000;

endpackage

// File: rtl/pe_acc_if.sv
// Product-beat input and result output handshake bundle of the PE back end.
// master = producer/consumer side, slave = the pe_acc block.
interface pe_acc_if #(
    parameter int LANES  = pe_pkg::LANES,
    parameter int PROD_W = pe_pkg::PROD_W,
    parameter int OUT_W  = pe_pkg::OUT_W,
    parameter int CNT_W  = pe_pkg::CNT_W
) ();

    logic                      in_valid;
    logic                      in_ready;
    logic                      in_last;
    logic [LANES*PROD_W-1:0]   mult_result;

    logic                      out_valid;
    logic                      out_ready;
    logic [OUT_W-1:0]          out_sum;
    logic                      out_ovf;
    logic [CNT_W-1:0]          out_cnt;

    modport master (
        output in_valid, in_last, mult_result, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf, out_cnt
    );

    modport slave (
        input  in_valid, in_last, mult_result, out_ready,
        output in_ready, out_valid, out_sum, out_ovf, out_cnt
    );

endinterface

// File: rtl/pe_add_tree.sv
// Two-stage pipelined reduction of one product beat: 4-lane groups, then the group partials.
// Latency 2 cycles; en_i low freezes every stage (valid/last sideband included).
module pe_add_tree #(
    parameter int LANES  = pe_pkg::LANES,
    parameter int PROD_W = pe_pkg::PROD_W,
    localparam int NGRP  = LANES / 4,
    localparam int P1_W  = PROD_W + 2,
    localparam int P2_W  = P1_W + $clog2(NGRP)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en_i,
    input  logic                    vld_i,
    input  logic                    last_i,
    input  logic [LANES*PROD_W-1:0] prod_i,
    output logic                    vld_o,
    output logic                    last_o,
    output logic signed [P2_W-1:0]  sum_o
);

    logic signed [P1_W-1:0] p1_d [NGRP];
    logic signed [P1_W-1:0] p1_q [NGRP];
    logic                   v1_q, last1_q;
    logic signed [P2_W-1:0] sum_d, sum_q;
    logic                   v2_q, last2_q;

    always_comb begin
        for (int g = 0; g < NGRP; g++) begin
            p1_d[g] = '0;
            for (int k = 0; k < 4; k++) begin
                p1_d[g] = p1_d[g] + {{2{prod_i[(g*4+k)*PROD_W + PROD_W-1]}},
                                     prod_i[(g*4+k)*PROD_W +: PROD_W]};
            end
        end
    end

    always_comb begin
        sum_d = '0;
        for (int g = 0; g < NGRP; g++) begin
            sum_d = sum_d + {{(P2_W-P1_W){p1_q[g][P1_W-1]}}, p1_q[g]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int g = 0; g < NGRP; g++) p1_q[g] <= '0;
            v1_q    <= 1'b0;
            last1_q <= 1'b0;
            sum_q   <= '0;
            v2_q    <= 1'b0;
            last2_q <= 1'b0;
        end else if (en_i) begin
            for (int g = 0; g < NGRP; g++) p1_q[g] <= p1_d[g];
            v1_q    <= vld_i;
            last1_q <= vld_i && last_i;
            sum_q   <= sum_d;
            v2_q    <= v1_q;
            last2_q <= last1_q;
        end
    end

    assign vld_o  = v2_q;
    assign last_o = last2_q;
    assign sum_o  = sum_q;

endmodule

// File: rtl/pe_acc.sv
// Reduces 32-lane product beats and accumulates them into one saturated int32 result per vector.
// Latency 3 edges from last-beat accept to out_valid; a held result (out_valid && !out_ready) freezes the whole pipe.
module pe_acc
    import pe_pkg::*;
#(
    parameter int LANES  = pe_pkg::LANES,
    parameter int PROD_W = pe_pkg::PROD_W,
    parameter int ACC_W  = pe_pkg::ACC_W,
    parameter int OUT_W  = pe_pkg::OUT_W,
    parameter int CNT_W  = pe_pkg::CNT_W
) (
    input  logic      clk,
    input  logic      rst_n,
    pe_acc_if.slave   bus
);

    localparam int NGRP = LANES / 4;
    localparam int P2_W = PROD_W + 2 + $clog2(NGRP);

    localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-OUT_W){1'b0}}, INT32_MAX};
    localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-OUT_W){1'b1}}, INT32_MIN};

    logic                    stall;
    logic                    v2, last2;
    logic signed [P2_W-1:0]  beat_sum;

    logic signed [ACC_W-1:0] acc_d, acc_q;
    logic [CNT_W-1:0]        cnt_d, cnt_q;
    logic                    first_d, first_q;
    logic                    out_vld_d, out_vld_q;
    logic [OUT_W-1:0]        out_sum_d, out_sum_q;
    logic                    out_ovf_d, out_ovf_q;
    logic [CNT_W-1:0]        out_cnt_d, out_cnt_q;

    logic signed [ACC_W-1:0] beat_ext, base, total;
    logic [CNT_W-1:0]        cnt_inc;
    logic                    sat_hi, sat_lo;

    assign stall        = out_vld_q && !bus.out_ready;
    assign bus.in_ready = !stall;

    pe_add_tree #(
        .LANES  (LANES),
        .PROD_W (PROD_W)
    ) u_tree (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (!stall),
        .vld_i  (bus.in_valid),
        .last_i (bus.in_last),
        .prod_i (bus.mult_result),
        .vld_o  (v2),
        .last_o (last2),
        .sum_o  (beat_sum)
    );

    // The first beat of a vector ignores whatever the accumulator still holds.
    always_comb begin
        beat_ext = {{(ACC_W-P2_W){beat_sum[P2_W-1]}}, beat_sum};
        base     = first_q ? '0 : acc_q;
        total    = base + beat_ext;
        cnt_inc  = first_q ? CNT_W'(1) : cnt_q + CNT_W'(1);
        sat_hi   = total > SAT_HI;
        sat_lo   = total < SAT_LO;
    end

    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        first_d   = first_q;
        out_vld_d = out_vld_q;
        out_sum_d = out_sum_q;
        out_ovf_d = out_ovf_q;
        out_cnt_d = out_cnt_q;
        if (!stall) begin
            out_vld_d = 1'b0;
            if (v2) begin
                if (last2) begin
                    out_vld_d = 1'b1;
                    out_sum_d = sat_hi ? INT32_MAX : (sat_lo ? INT32_MIN : total[OUT_W-1:0]);
                    out_ovf_d = sat_hi || sat_lo;
                    out_cnt_d = cnt_inc;
                    acc_d     = '0;
                    cnt_d     = '0;
                    first_d   = 1'b1;
                end else begin
                    acc_d     = total;
                    cnt_d     = cnt_inc;
                    first_d   = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            first_q   <= 1'b1;
            out_vld_q <= 1'b0;
            out_sum_q <= '0;
            out_ovf_q <= 1'b0;
            out_cnt_q <= '0;
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            first_q   <= first_d;
            out_vld_q <= out_vld_d;
            out_sum_q <= out_sum_d;
            out_ovf_q <= out_ovf_d;
            out_cnt_q <= out_cnt_d;
        end
    end

    assign bus.out_valid = out_vld_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_ovf   = out_ovf_q;
    assign bus.out_cnt   = out_cnt_q;

endmodule
